// File: rtl/crypto1_keystream.sv
// Forward Crypto1 keystream generator.
// Loads a 48-bit key into the cipher LFSR, optionally shifts in an
// initialisation word, then emits filter-function bits over a valid/ready
// stream while collecting them into a 48-bit BITSTREAM word
// (BITSTREAM[n] is the n-th accepted bit).
module crypto1_keystream #(
  parameter int NBITS     = 48,
  parameter int INIT_BITS = 32
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        START,
  input  logic [47:0] KEY,
  input  logic [31:0] INJECT,
  output logic        KS_BIT,
  output logic        KS_VALID,
  input  logic        KS_READY,
  output logic [47:0] BITSTREAM,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_INIT   = 2'd1,
    S_STREAM = 2'd2,
    S_FINISH = 2'd3
  } state_e;

  // Feedback taps x0,x5,x9,x10,x12,x14,x15,x17,x19,x24,x25,x27,x29,x35,x39,x41,x42,x43.
  localparam logic [47:0] L_TAPS = 48'h0E88_2B0A_D621;
  localparam logic [5:0]  N_LAST = 6'(NBITS - 1);
  localparam logic [5:0]  J_LAST = 6'(INIT_BITS - 1);

  state_e      state_q, state_d;
  logic [47:0] x_q, x_d;
  logic [31:0] inj_q, inj_d;
  logic [47:0] bits_q, bits_d;
  logic [5:0]  n_q, n_d;
  logic [5:0]  j_q, j_d;

  logic        lin_w;
  logic        ks_bit_w;
  logic        hs_w;

  function automatic logic fa(input logic a, input logic b, input logic c, input logic d);
    return ((a | b) ^ (a & d)) ^ (c & ((a ^ b) | d));
  endfunction

  function automatic logic fb(input logic a, input logic b, input logic c, input logic d);
    return ((a & b) | c) ^ ((a ^ b) & (c | d));
  endfunction

  function automatic logic fc(input logic a, input logic b, input logic c, input logic d,
                              input logic e);
    return (a | ((b | e) & (d ^ e))) ^ ((a ^ (b & d)) & ((c ^ d) | (b & e)));
  endfunction

  // Linear feedback L(x): parity of the tapped cells.
  assign lin_w = ^(x_q & L_TAPS);

  // A stream bit is consumed only while streaming and the sink is ready.
  assign hs_w = (state_q == S_STREAM) && KS_READY;

  // Nonlinear filter f(x), purely from the registered LFSR state.
  always_comb begin
    ks_bit_w = fc(fa(x_q[9],  x_q[11], x_q[13], x_q[15]),
                  fb(x_q[17], x_q[19], x_q[21], x_q[23]),
                  fb(x_q[25], x_q[27], x_q[29], x_q[31]),
                  fa(x_q[33], x_q[35], x_q[37], x_q[39]),
                  fb(x_q[41], x_q[43], x_q[45], x_q[47]));
  end

  // State register.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: START only matters in IDLE, so pulses while busy are dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (START) state_d = (INIT_BITS == 0) ? S_STREAM : S_INIT;
      S_INIT:   if (j_q == J_LAST) state_d = S_STREAM;
      S_STREAM: if (hs_w && (n_q == N_LAST)) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    KS_VALID  = (state_q == S_STREAM);
    KS_BIT    = (state_q == S_STREAM) & ks_bit_w;
    BUSY      = (state_q == S_INIT) || (state_q == S_STREAM);
    DONE      = (state_q == S_FINISH);
    BITSTREAM = bits_q;
  end

  // Datapath next values: key load, init shifts, and stream shifts on handshake.
  always_comb begin
    x_d    = x_q;
    inj_d  = inj_q;
    bits_d = bits_q;
    n_d    = n_q;
    j_d    = j_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          x_d    = KEY;
          inj_d  = INJECT;
          bits_d = '0;
          n_d    = '0;
          j_d    = '0;
        end
      end
      S_INIT: begin
        x_d = {lin_w ^ inj_q[j_q[4:0]], x_q[47:1]};
        j_d = j_q + 6'd1;
      end
      S_STREAM: begin
        if (hs_w) begin
          bits_d[n_q] = ks_bit_w;
          x_d         = {lin_w, x_q[47:1]};
          n_d         = n_q + 6'd1;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers; reset clears everything so an abort leaves no trace.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      x_q    <= '0;
      inj_q  <= '0;
      bits_q <= '0;
      n_q    <= '0;
      j_q    <= '0;
    end else begin
      x_q    <= x_d;
      inj_q  <= inj_d;
      bits_q <= bits_d;
      n_q    <= n_d;
      j_q    <= j_d;
    end
  end

endmodule
